// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: handshake bundle between NREQ requesters, the arbiter and the shared fifo.
//   req_valid_i  requester i has a beat (bit i)
//   req_data_i   packed requester data, requester i at [i*SIZEDATA +: SIZEDATA]
//   req_ready_o  one-hot accept strobe back to the requesters
//   out_valid_o  registered beat valid (to fifo valid_i)
//   out_data_o   registered beat data (to fifo data_i)
//   out_id_o     index of the requester that sourced out_data_o
//   out_ready_i  fifo accepts (from fifo ready_o)
// Modports: master = arbiter side, slave = requesters + fifo side.
interface fifo_rr_arbiter_if #(
    parameter int unsigned SIZEDATA = 32,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDBITS   = $clog2(NREQ)
);
    logic [NREQ-1:0]          req_valid_i;
    logic [NREQ*SIZEDATA-1:0] req_data_i;
    logic [NREQ-1:0]          req_ready_o;
    logic                     out_valid_o;
    logic [SIZEDATA-1:0]      out_data_o;
    logic [IDBITS-1:0]        out_id_o;
    logic                     out_ready_i;

    modport master (
        input  req_valid_i, req_data_i, out_ready_i,
        output req_ready_o, out_valid_o, out_data_o, out_id_o
    );

    modport slave (
        output req_valid_i, req_data_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_data_o, out_id_o
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin arbiter sharing one fifo write port among NREQ requesters.
// One output register stage: 1-cycle latency, 1 beat/cycle throughput.
// Ports:
//   clk_i   clock, rising edge
//   rstn_i  asynchronous active-low reset
//   bus     fifo_rr_arbiter_if.master (requester valid/data/ready, registered out stream)
// Optional feature (macro ARB_BURST_EN): after an accept the arbiter locks to that requester
// for up to BURSTLEN consecutive beats while it stays valid.
module fifo_rr_arbiter #(
    parameter int unsigned SIZEDATA = 32,
    parameter int unsigned NREQ     = 4,
`ifdef ARB_BURST_EN
    parameter int unsigned BURSTLEN = 4,
`endif
    parameter int unsigned IDBITS   = $clog2(NREQ)
) (
    input logic               clk_i,
    input logic               rstn_i,
    fifo_rr_arbiter_if.master bus
);
    logic                load_en;
    logic                win_found;
    logic [IDBITS-1:0]   win_idx;
    logic [IDBITS-1:0]   ptr_q, ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [SIZEDATA-1:0] out_data_q, out_data_d;
    logic [IDBITS-1:0]   out_id_q, out_id_d;
    logic [NREQ-1:0]     req_ready;
    logic [SIZEDATA-1:0] req_data [NREQ];

`ifdef ARB_BURST_EN
    localparam int unsigned CntBits = $clog2(BURSTLEN + 1);
    logic               lock_q, lock_d;
    logic [IDBITS-1:0]  owner_q, owner_d;
    logic [CntBits-1:0] count_q, count_d;
    logic [CntBits-1:0] count_next;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_data[g] = bus.req_data_i[g*SIZEDATA +: SIZEDATA];
    end

    // Output register is empty or drains this cycle.
    assign load_en = ~out_valid_q | bus.out_ready_i;

    // Search from ptr upward; explicit wrap keeps non-power-of-two NREQ correct.
    always_comb begin : p_select
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && bus.req_valid_i[IDBITS'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDBITS'(idx);
            end
        end
`ifdef ARB_BURST_EN
        // A locked owner that is still valid overrides the round-robin pick.
        if (lock_q && bus.req_valid_i[owner_q]) begin
            win_found = 1'b1;
            win_idx   = owner_q;
        end
`endif
    end

    // Gated by rstn_i so no requester sees ready while reset is held.
    always_comb begin
        req_ready = '0;
        if (rstn_i && load_en && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (win_found) begin
                out_valid_d = 1'b1;
                out_data_d  = req_data[win_idx];
                out_id_d    = win_idx;
                ptr_d       = (win_idx == IDBITS'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

`ifdef ARB_BURST_EN
    // ptr already points past the owner on every accept, so releasing the lock
    // resumes round-robin from owner+1 without extra pointer handling.
    always_comb begin
        lock_d     = lock_q;
        owner_d    = owner_q;
        count_d    = count_q;
        count_next = '0;
        if (load_en) begin
            if (win_found) begin
                count_next = (lock_q && (win_idx == owner_q)) ? count_q + 1'b1 : CntBits'(1);
                if (count_next == CntBits'(BURSTLEN)) begin
                    lock_d  = 1'b0;
                    count_d = '0;
                end else begin
                    lock_d  = 1'b1;
                    owner_d = win_idx;
                    count_d = count_next;
                end
            end else begin
                lock_d  = 1'b0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
            count_q <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            count_q <= count_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_id_o    = out_id_q;
endmodule
